// File: rtl/utils_pkg.sv
// Shared types and constants for the SPI request arbiter.
package utils_pkg;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RX = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  // Every transaction moves exactly one byte through the SPI controller.
  localparam logic [1:0] TX_COUNT = 2'd1;

  // RX wait budget in clock cycles when the instantiating level does not override it.
  localparam int DEFAULT_TIMEOUT_CLKS = 255;

endpackage

// File: rtl/spi_rr_picker.sv
// Round-robin next-grant selector: purely combinational. The search starts
// at the requester just after the last one granted and wraps around, so the
// last winner gets the lowest priority in the next round.
module spi_rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IW-1:0]      i_last_grant,
  output logic               o_found,
  output logic [IW-1:0]      o_grant
);

  logic [IW-1:0] w_idx;

  // Walk the requesters in rotated order and keep the first valid one.
  // NOTE: every variable gets a default before the loop and only blocking '='
  // is used here, so this stays pure combinational logic with no latches.
  always_comb begin
    o_found = 1'b0;
    o_grant = '0;
    w_idx   = i_last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_idx == IW'(NUM_REQ - 1)) begin
        w_idx = '0;
      end else begin
        w_idx = w_idx + IW'(1);
      end
      if (!o_found && i_valid[w_idx]) begin
        o_found = 1'b1;
        o_grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one single-byte SPI controller between NUM_REQ requesters.
// A transaction is: grant (accept pulse) -> one TX strobe -> wait for the RX
// byte or a timeout -> one response pulse back to the granted requester.
// Every output comes straight from a flop.
module spi_req_arbiter
  import utils_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS,
  localparam int IW           = $clog2(NUM_REQ)
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Rsp_Valid,
  output logic [7:0]           o_Rsp_Byte,
  output logic                 o_Rsp_Err,
  output logic [1:0]           o_TX_Count,
  output logic [7:0]           o_TX_Byte,
  output logic                 o_TX_DV,
  input  logic                 i_TX_Ready,
  input  logic                 i_RX_DV,
  input  logic [7:0]           i_RX_Byte,
  output logic                 o_Busy,
  output logic [IW-1:0]        o_Grant_Id
);

  // Last timer value before the wait is abandoned.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CLKS - 1);

  // Registered state and outputs.
  arb_state_t           r_state;
  logic [IW-1:0]        r_last_grant;
  logic [IW-1:0]        r_grant_id;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [7:0]           r_rsp_byte;
  logic                 r_rsp_err;
  logic [7:0]           r_tx_byte;
  logic                 r_tx_dv;
  logic                 r_busy;
  logic [15:0]          r_timer;

  // Next-cycle values produced by the decision logic.
  arb_state_t           w_nxt_state;
  logic [IW-1:0]        w_nxt_last_grant;
  logic [IW-1:0]        w_nxt_grant_id;
  logic [NUM_REQ-1:0]   w_nxt_req_ready;
  logic [NUM_REQ-1:0]   w_nxt_rsp_valid;
  logic [7:0]           w_nxt_rsp_byte;
  logic                 w_nxt_rsp_err;
  logic [7:0]           w_nxt_tx_byte;
  logic                 w_nxt_tx_dv;
  logic [15:0]          w_nxt_timer;

  // Round-robin candidate for the current cycle.
  logic                 w_pick_found;
  logic [IW-1:0]        w_pick_idx;
  logic [NUM_REQ-1:0]   w_pick_onehot;
  logic [NUM_REQ-1:0]   w_grant_onehot;
  logic [7:0]           w_pick_byte;

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_valid      (i_Req_Valid),
    .i_last_grant (r_last_grant),
    .o_found      (w_pick_found),
    .o_grant      (w_pick_idx)
  );

  assign w_pick_onehot  = NUM_REQ'(1) << w_pick_idx;
  assign w_grant_onehot = NUM_REQ'(1) << r_grant_id;
  assign w_pick_byte    = i_Req_Byte[{w_pick_idx, 3'b000} +: 8];

  // Next-state and next-output decisions; pulses default low, held values default to themselves.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_last_grant = r_last_grant;
    w_nxt_grant_id   = r_grant_id;
    w_nxt_req_ready  = '0;
    w_nxt_rsp_valid  = '0;
    w_nxt_rsp_byte   = r_rsp_byte;
    w_nxt_rsp_err    = r_rsp_err;
    w_nxt_tx_byte    = r_tx_byte;
    w_nxt_tx_dv      = 1'b0;
    w_nxt_timer      = r_timer;

    case (r_state)
      ST_IDLE: begin
        // A busy controller blocks all grants; RX strobes are ignored here.
        if (i_TX_Ready && w_pick_found) begin
          w_nxt_state      = ST_ISSUE;
          w_nxt_req_ready  = w_pick_onehot;
          w_nxt_tx_byte    = w_pick_byte;
          w_nxt_grant_id   = w_pick_idx;
          w_nxt_last_grant = w_pick_idx;
        end
      end
      ST_ISSUE: begin
        w_nxt_tx_dv = 1'b1;
        w_nxt_timer = '0;
        w_nxt_state = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        // RX data wins over a timeout landing in the same cycle.
        if (i_RX_DV) begin
          w_nxt_rsp_byte  = i_RX_Byte;
          w_nxt_rsp_err   = 1'b0;
          w_nxt_rsp_valid = w_grant_onehot;
          w_nxt_state     = ST_RESP;
        end else if (r_timer == TIMER_LAST) begin
          w_nxt_rsp_byte  = 8'h00;
          w_nxt_rsp_err   = 1'b1;
          w_nxt_rsp_valid = w_grant_onehot;
          w_nxt_state     = ST_RESP;
        end else begin
          w_nxt_timer = r_timer + 16'd1;
        end
      end
      ST_RESP: begin
        // The response pulse is on the outputs during this cycle.
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction silently.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values, and the asynchronous reset sits in the sensitivity list.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IW'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_byte   <= 8'h00;
      r_rsp_err    <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_tx_dv      <= 1'b0;
      r_busy       <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_last_grant <= w_nxt_last_grant;
      r_grant_id   <= w_nxt_grant_id;
      r_req_ready  <= w_nxt_req_ready;
      r_rsp_valid  <= w_nxt_rsp_valid;
      r_rsp_byte   <= w_nxt_rsp_byte;
      r_rsp_err    <= w_nxt_rsp_err;
      r_tx_byte    <= w_nxt_tx_byte;
      r_tx_dv      <= w_nxt_tx_dv;
      r_busy       <= (w_nxt_state != ST_IDLE);
      r_timer      <= w_nxt_timer;
    end
  end

  assign o_Req_Ready = r_req_ready;
  assign o_Rsp_Valid = r_rsp_valid;
  assign o_Rsp_Byte  = r_rsp_byte;
  assign o_Rsp_Err   = r_rsp_err;
  assign o_TX_Count  = TX_COUNT;
  assign o_TX_Byte   = r_tx_byte;
  assign o_TX_DV     = r_tx_dv;
  assign o_Busy      = r_busy;
  assign o_Grant_Id  = r_grant_id;

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one SPI controller, range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 255: the maximum number of i_Clk cycles to wait for RX data, range 16..65535.
REQ-003 SHALL have these ports (name, direction, width, meaning); the clock is i_Clk and the reset is i_Rst_L, which is asynchronous and active-low:
  i_Clk  in  1  system clock, rising edge
  i_Rst_L  in  1  asynchronous active-low reset
  i_Req_Valid  in  NUM_REQ  per-requester request valid, held until accepted
  i_Req_Byte  in  8*NUM_REQ  per-requester TX byte; requester k uses bits [8k+7:8k]
  o_Req_Ready  out  NUM_REQ  one-hot, one-cycle accept pulse
  o_Rsp_Valid  out  NUM_REQ  one-hot, one-cycle response pulse
  o_Rsp_Byte  out  8  response byte, valid with o_Rsp_Valid
  o_Rsp_Err  out  1  timeout flag, valid with o_Rsp_Valid
  o_TX_Count  out  2  byte count to the controller, constant 1
  o_TX_Byte  out  8  byte to the controller
  o_TX_DV  out  1  one-cycle transmit strobe to the controller
  i_TX_Ready  in  1  controller idle/ready
  i_RX_DV  in  1  controller received-byte strobe
  i_RX_Byte  in  8  controller received byte
  o_Busy  out  1  high in every state except IDLE
  o_Grant_Id  out  $clog2(NUM_REQ)  index of the current or last granted requester

Function
REQ-004 SHALL implement the states IDLE, ISSUE, WAIT_RX and RESP; all outputs SHALL be registered.
REQ-005 In IDLE, when i_TX_Ready=1 and any i_Req_Valid bit is set, SHALL grant round-robin, searching from (last_grant+1) mod NUM_REQ upward.
REQ-006 On a grant SHALL, in the next cycle: pulse o_Req_Ready[g] for one cycle, latch the granted byte, set o_Grant_Id=g, update last_grant=g, and enter ISSUE.
REQ-007 In IDLE with i_TX_Ready=0, SHALL make no grant, regardless of request state.
REQ-008 ISSUE SHALL drive o_TX_DV=1 for exactly one cycle with o_TX_Byte holding the latched byte, then enter WAIT_RX with the timer cleared.
REQ-009 In WAIT_RX, i_RX_DV=1 SHALL capture i_RX_Byte, set the error flag to 0 and enter RESP.
REQ-010 In WAIT_RX the timer SHALL increment once per cycle; on reaching TIMEOUT_CLKS-1 without i_RX_DV, the block SHALL enter RESP with the error flag set to 1 and the response byte set to 0x00.
REQ-011 If i_RX_DV and the timeout occur in the same cycle, the block SHALL treat it as success (error flag 0).
REQ-012 RESP SHALL pulse o_Rsp_Valid[g] for one cycle, with o_Rsp_Byte and o_Rsp_Err stable during that cycle, then return to IDLE.
REQ-013 i_RX_DV received outside WAIT_RX SHALL be ignored.
REQ-014 A request deasserted before its o_Req_Ready pulse SHALL NOT be granted; its requester SHALL keep its round-robin position.
REQ-015 A requester that is never granted SHALL be granted within NUM_REQ transactions of any other requester (starvation-free).
REQ-016 Minimum latency from request seen in IDLE to o_TX_DV SHALL be 2 cycles.
REQ-017 o_TX_Count SHALL be the constant 2'd1.

Reset
REQ-018 While i_Rst_L=0 the block SHALL be in IDLE with these values: last_grant=NUM_REQ-1, so that requester 0 is served first; o_Req_Ready=0; o_Rsp_Valid=0; o_Rsp_Byte=0; o_Rsp_Err=0; o_TX_DV=0; o_TX_Byte=0; o_Busy=0; o_Grant_Id=0; timer=0.
REQ-019 A reset in any state SHALL abort the transaction without issuing a response pulse; requesters re-present their requests after reset.

Structure
REQ-020 The state enum, the TX count constant and the default timeout value SHALL be placed in the shared utils_pkg.
REQ-021 A sub-module spi_rr_picker, a combinational round-robin next-grant function of the valid vector and last_grant, SHALL be instantiated once.

Verification
REQ-022 Single request: requester 2 sends 0xA5; the controller returns 0x5A -> o_Req_Ready[2] pulse, o_TX_Byte=0xA5 with o_TX_DV, o_Rsp_Valid[2] pulse, o_Rsp_Byte=0x5A, o_Rsp_Err=0.
REQ-023 Contention: all 4 requesters valid from reset with bytes 0x10..0x13 -> grant order 0,1,2,3, then 0 again if it re-requests.
REQ-024 Timeout: no i_RX_DV with TIMEOUT_CLKS=32 -> o_Rsp_Err=1 and o_Rsp_Byte=0x00 exactly 32 cycles after entering WAIT_RX.
REQ-025 Backpressure: i_TX_Ready=0 for 50 cycles while requester 1 is valid -> no grant; grant occurs 1 cycle after i_TX_Ready rises.
REQ-026 Reset in WAIT_RX: i_Rst_L pulsed low -> all outputs take their reset values, no o_Rsp_Valid pulse, next grant goes to requester 0.
REQ-027 Stray strobe: i_RX_DV pulsed in IDLE -> no response pulse and no state change.
